// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// apb_rr_arbiter : round-robin sequencer sharing one APB bus among NUM_REQ
// Rev 1.0
// ------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                      busy_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic                      pready_i,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pslverr_i
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [IDW-1:0]     r_gid, r_last, w_pick;
  logic [CW-1:0]      r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_write;
  logic               w_found, w_grant, w_done, w_tmo;
  int                 w_idx;

  // Search starts just after the last winner so it drops to lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = (int'(r_last) + i) % NUM_REQ;
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = IDW'(w_idx);
      end
    end
  end

  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          w_next  = S_SETUP;
        end
      end
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: begin
        // A transfer cut short by reset is never acknowledged.
        if (!reset && (pready_i || w_tmo)) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gid   <= '0;
      r_last  <= IDW'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gid   <= w_pick;
        r_addr  <= req_addr_i[int'(w_pick)*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata_i[int'(w_pick)*DATA_W +: DATA_W];
        r_write <= req_write_i[w_pick];
      end
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end else if (r_state == S_ACCESS && !w_done) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_done) begin
        r_last <= r_gid;
      end
    end
  end

  assign psel_o     = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable_o  = (r_state == S_ACCESS);
  assign busy_o     = psel_o;
  assign grant_id_o = r_gid;
  assign paddr_o    = r_addr;
  assign pwrite_o   = r_write;
  assign pwdata_o   = r_wdata;

  // Timeout aborts report an error regardless of pslverr_i.
  always_comb begin
    ack_o   = '0;
    err_o   = '0;
    rdata_o = '0;
    if (w_done) begin
      ack_o[r_gid] = 1'b1;
      err_o[r_gid] = pready_i ? pslverr_i : 1'b1;
      if (pready_i && !r_write) begin
        rdata_o = prdata_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_apb_rr_arbiter : directed and randomized checks against a transaction model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_apb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_wr;
  logic [AW-1:0] a  [N];
  logic [DW-1:0] wd [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  ack, err;
  logic [DW-1:0] rdata;
  logic [1:0]    gid;
  logic          busy, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  assign req_addr  = {a[3], a[2], a[1], a[0]};
  assign req_wdata = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  apb_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_i(req), .req_write_i(req_wr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .ack_o(ack), .err_o(err), .rdata_o(rdata), .grant_id_o(gid), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: phase 0 idle, 1 setup, n>=2 is access cycle n-1.
  bit            m_valid = 1'b0;
  int            m_phase, m_own, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_wr;
  logic [N-1:0]  m_ack_last = '0;

  // Winner is the requester closest after the last winner, going upward.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int k = 0; k < N; k++) begin
      if (r[k]) begin
        d = (k - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  always @(negedge clk) begin : p_compare
    logic [N-1:0]  e_ack, e_err;
    logic [DW-1:0] e_rd;
    bit            done;
    int            w;
    done = (m_phase >= 2) && !reset && (pready || (m_phase - 1) == TO);
    if (m_valid) begin
      e_ack = '0;
      e_err = '0;
      if (done) begin
        e_ack[m_own] = 1'b1;
        e_err[m_own] = pready ? pslverr : 1'b1;
      end
      e_rd = (done && pready && !m_wr) ? prdata : '0;
      chk("m_psel", psel, m_phase > 0);
      chk("m_penable", penable, m_phase >= 2);
      chk("m_busy", busy, m_phase > 0);
      chk("m_paddr", paddr, m_addr);
      chk("m_pwdata", pwdata, m_wdata);
      chk("m_pwrite", pwrite, m_wr);
      chk("m_grant", gid, m_own);
      chk("m_ack", ack, e_ack);
      chk("m_err", err, e_err);
      chk("m_rdata", rdata, e_rd);
      m_ack_last = e_ack;
    end else begin
      m_ack_last = '0;
    end
    if (reset) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_last  = N - 1;
      m_own   = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_wr    = 1'b0;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        w = rr_pick(req, m_last);
        if (w >= 0) begin
          m_own   = w;
          m_addr  = a[w];
          m_wdata = wd[w];
          m_wr    = req_wr[w];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (done) begin
        m_last  = m_own;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  bit act [N];
  int stall = 0;

  initial begin
    logic [N-1:0] e;
    reset = 1'b1; req = '0; req_wr = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    for (int k = 0; k < N; k++) begin
      a[k] = '0; wd[k] = '0; act[k] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_grant", gid, 0);

    // single read, zero wait states
    tick(); reset = 1'b0; req = 4'b0001; a[0] = 32'h10; pready = 1'b1; prdata = 32'h12345678;
    @(negedge clk); chk("rd_idle_psel", psel, 0);
    tick(); @(negedge clk);
    chk("rd_setup_psel", psel, 1); chk("rd_setup_pen", penable, 0); chk("rd_paddr", paddr, 32'h10);
    tick(); @(negedge clk);
    chk("rd_acc_pen", penable, 1); chk("rd_ack", ack, 4'b0001);
    chk("rd_rdata", rdata, 32'h12345678); chk("rd_err", err, 0);

    // write with three wait states
    tick(); req = 4'b0100; req_wr = 4'b0100; a[2] = 32'h20; wd[2] = 32'hDEADBEEF; pready = 1'b0;
    @(negedge clk); chk("wr_idle_psel", psel, 0);
    tick(); @(negedge clk); chk("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) pready = 1'b1;
      @(negedge clk);
      chk("wr_pwdata", pwdata, 32'hDEADBEEF);
      chk("wr_ack", ack, (i == 3) ? 4'b0100 : 4'b0000);
      if (i == 3) chk("wr_rdata", rdata, 0);
    end

    // timeout abort on a read from requester 1
    tick(); req = 4'b0010; req_wr = 4'b0000; a[1] = 32'h30; pready = 1'b0;
    @(negedge clk); chk("to_idle_psel", psel, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk("to_ack", ack, (i == 3) ? 4'b0010 : 4'b0000);
      chk("to_err", err, (i == 3) ? 4'b0010 : 4'b0000);
      if (i == 3) chk("to_rdata", rdata, 0);
    end

    // slave error on a read from requester 3
    tick(); req = 4'b1000; a[3] = 32'h40;
    @(negedge clk); chk("to_release_psel", psel, 0);
    tick(); tick(); pready = 1'b1; pslverr = 1'b1;
    @(negedge clk); chk("se_ack", ack, 4'b1000); chk("se_err", err, 4'b1000);

    // reset during a wait state, then fairness with all requesters held
    tick(); req = 4'b0100; req_wr = 4'b0100; pready = 1'b0; pslverr = 1'b0;
    tick(); tick(); tick(); reset = 1'b1;
    @(negedge clk); chk("mr_cycle_ack", ack, 0);
    tick(); req = 4'b1111; pready = 1'b1;
    @(negedge clk);
    chk("mr_psel", psel, 0); chk("mr_penable", penable, 0); chk("mr_busy", busy, 0); chk("mr_ack", ack, 0);
    tick(); reset = 1'b0;
    @(negedge clk); chk("fair_idle0", psel, 0);
    for (int t = 0; t < 5; t++) begin
      tick(); tick(); @(negedge clk);
      e = 4'b0001 << (t % 4);
      chk("fair_grant", gid, t % 4);
      chk("fair_ack", ack, e);
      tick(); @(negedge clk);
      chk("fair_idle", psel, 0);
    end
    tick(); req = '0; pready = 1'b0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < N; k++) begin
        if (m_ack_last[k]) act[k] = 1'b0;
        if (!act[k] && $urandom_range(0, 1) == 0) begin
          act[k]    = 1'b1;
          a[k]      = $urandom;
          wd[k]     = $urandom;
          req_wr[k] = 1'($urandom_range(0, 1));
        end
        req[k] = act[k];
      end
      if (stall > 0) begin
        pready = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(0, 19) == 0) stall = $urandom_range(3, 6);
        pready = ($urandom_range(0, 2) != 0);
      end
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
    end
    tick(); reset = 1'b0; req = '0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
